mmul_seq: RTL and testbench
===========================

# mmul_seq

Multi-cycle sequencer for the `MATRIX_MUL` ALU operation (alu_op `3'b101`). When the EX stage issues a matrix multiply, this block stalls the pipeline. It walks an N×N × N×N product element by element, fetching operands from the data scratchpad over a single request/grant/rvalid port. It accumulates each element with one shared multiply-accumulate unit and writes each result element back. It sits beside the ALU in EX and owns the data-memory port while busy.

## Interface
- `N`, 4: matrix dimension (1..8).
- `DW`, 32: element and data width.
- `AW`, 32: byte address width.

- `clk` in 1: clock.
- `rstn` in 1: synchronous, active-low reset.
- `start` in 1: EX-stage valid and alu_ctrl == `MATRIX_MUL`.
- `a_base` in AW: byte address of A, row-major (rs1 value).
- `b_base` in AW: byte address of B (rs2 value).
- `c_base` in AW: byte address of C.
- `busy` out 1: pipeline stall request.
- `done` out 1: one-cycle completion pulse.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out AW: byte address.
- `mem_wdata` out DW: write data.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in DW: read data.

## Operation
- FSM states: IDLE, RD_A, WT_A, RD_B, WT_B, MAC, WR, DONE.
- IDLE: when `start`=1, latch the three bases, clear i/j/k and acc, and go to RD_A. Otherwise stay.
- RD_A: `mem_req`=1, `mem_we`=0, addr = a_base + 4·(i·N+k). On `mem_gnt`, go to WT_A. Otherwise hold all outputs stable.
- WT_A: on `mem_rvalid`, latch the operand into opa and go to RD_B.
- RD_B/WT_B: same pattern, addr = b_base + 4·(k·N+j), latching opb.
- MAC: acc ← acc + opa·opb, using the low DW bits of a signed product. If k==N−1, go to WR. Otherwise increment k and go to RD_A.
- WR: `mem_req`=1, `mem_we`=1, addr = c_base + 4·(i·N+j), wdata = acc.
  - On `mem_gnt`, clear acc and k.
  - Advance j; when j wraps, advance i.
  - After the last element (i=j=N−1), go to DONE. Otherwise go to RD_A.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^AW; wraparound is silent.
- `mem_rvalid` outside WT_A/WT_B is ignored.
- `start` while not in IDLE is ignored. No queueing.
- N=1: a single element, with WR immediately after the first MAC.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Internal state is IDLE, all counters 0, acc 0.
- `busy` is registered. It is 1 in every state except IDLE.
  - It rises the cycle after `start` is sampled.
  - It falls the cycle after DONE.
- All memory outputs are driven combinationally from registered state.
- With `mem_gnt` tied high and `mem_rvalid` one cycle after the grant:
  - Each k step takes 5 cycles; each element takes 5N+1 cycles.
  - `done` asserts N²(5N+1)+1 cycles after the `start` sample cycle.
  - For N=2, that is cycle 45.
- Each cycle of withheld `mem_gnt` or late `mem_rvalid` adds exactly one cycle.
- Reset mid-operation:
  - The next edge returns to IDLE and drops `mem_req`/`busy`.
  - No `done` pulse is produced.
  - A partial C remains in memory.

## Configuration
- `MMUL_SAT_EN` defined: the accumulate saturates to signed DW range (0x7FFFFFFF / 0x80000000 for DW=32). Each product is formed at 2·DW and saturated before the add.
- Not defined: the low-DW product is added with wraparound, matching `ADD` semantics.

## Structure
- Shared `define.vh` additions:
  - `MATRIX_MUL` code (already present).
  - MMUL FSM state encodings.
  - `MMUL_N_MAX`.
- Sub-module `mmul_mac`:
  - Ports: opa, opb, acc_in → acc_out.
  - Combinational; contains the `MMUL_SAT_EN` logic.
- The FSM, counters and address generation stay in `mmul_seq`.

## Test plan
- N=2, A=identity, B={1,2,3,4}, gnt=1, rvalid one cycle later:
  - C writes {1,2,3,4} at c_base+0/4/8/12 in that order.
  - `done` at cycle 45.
  - `busy` is high on cycles 1–45.
- Same as above, with `mem_gnt` low for 3 cycles on the first RD_B:
  - `mem_addr` is held at b_base.
  - `done` moves to cycle 48.
- `start` pulsed again at cycle 10: ignored; exactly one `done`.
- A={0x7FFFFFFF,0;0,0}, B={2,0;0,0}:
  - With `MMUL_SAT_EN`, C[0][0]=0x7FFFFFFF.
  - Without it, C[0][0]=0xFFFFFFFE.
- `rstn`=0 at cycle 20:
  - Next cycle `busy`=0 and `mem_req`=0; no `done`.
  - A new `start` completes normally.
- a_base=0xFFFFFFF8, N=2: address 0xFFFFFFF8 is issued, then 0x00000000 after wraparound.

Source files
------------

// File: rtl/mmul_seq_pkg.sv
// rtl/mmul_seq_pkg.sv - shared types and constants for the matrix-multiply sequencer
// Contents:
//   MATRIX_MUL   alu_op code that launches the sequencer
//   MMUL_N_MAX   largest supported matrix dimension
//   mmul_state_e sequencer FSM state encoding
//   flat_idx()   row-major element index helper
package mmul_seq_pkg;

  localparam logic [2:0] MATRIX_MUL = 3'b101;
  localparam int MMUL_N_MAX = 8;

  // i/j/k counter width and row-major flat index width (N_MAX^2 elements)
  localparam int CW = $clog2(MMUL_N_MAX);
  localparam int IW = 2 * CW;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_WT_A = 3'd2,
    S_RD_B = 3'd3,
    S_WT_B = 3'd4,
    S_MAC  = 3'd5,
    S_WR   = 3'd6,
    S_DONE = 3'd7
  } mmul_state_e;

  function automatic logic [IW-1:0] flat_idx(input logic [CW-1:0] row,
                                             input logic [CW-1:0] col,
                                             input int n);
    return IW'(row) * IW'(n) + IW'(col);
  endfunction

endpackage

// File: rtl/mmul_seq_if.sv
// rtl/mmul_seq_if.sv - data-scratchpad request/grant/rvalid port
// Signals:
//   mem_req/mem_we/mem_addr/mem_wdata  request side, driven by the sequencer
//   mem_gnt                            request accepted this cycle
//   mem_rvalid/mem_rdata               read data return
// Modports: master (sequencer), slave (memory)
interface mmul_seq_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mmul_mac.sv
// rtl/mmul_mac.sv - combinational signed multiply-accumulate for one k step
// Ports:
//   opa, opb  in  DW  signed operands
//   acc_in    in  DW  running sum
//   acc_out   out DW  acc_in + opa*opb
// Macro MMUL_SAT_EN: product formed at 2*DW and saturated, then saturating add.
// Without it the low DW product bits are added with wraparound.
module mmul_mac #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic [DW-1:0] acc_in,
  output logic [DW-1:0] acc_out
);

`ifdef MMUL_SAT_EN
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [2*DW-1:0] prod;
  logic        [DW-1:0]   prod_sat;
  logic        [DW:0]     sum;

  always_comb begin
    prod = $signed(opa) * $signed(opb);
    // product fits in DW bits only when its top DW+1 bits are all sign copies
    if (&prod[2*DW-1:DW-1] || ~|prod[2*DW-1:DW-1]) begin
      prod_sat = prod[DW-1:0];
    end else begin
      prod_sat = prod[2*DW-1] ? SMIN : SMAX;
    end
    sum = {prod_sat[DW-1], prod_sat} + {acc_in[DW-1], acc_in};
    // the extra sign bit disagrees with the DW sign bit only on overflow
    if (sum[DW] != sum[DW-1]) begin
      acc_out = sum[DW] ? SMIN : SMAX;
    end else begin
      acc_out = sum[DW-1:0];
    end
  end
`else
  // the low DW bits of a signed product equal those of the unsigned product
  logic [DW-1:0] prod_lo;

  always_comb begin
    prod_lo = opa * opb;
    acc_out = acc_in + prod_lo;
  end
`endif

endmodule

// File: rtl/mmul_seq.sv
// rtl/mmul_seq.sv - multi-cycle N x N matrix-multiply sequencer beside the EX ALU
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   start                EX valid with MATRIX_MUL; sampled only in IDLE
//   a_base/b_base/c_base byte base addresses of row-major A, B, C
//   busy                 registered stall request, high in every non-IDLE state
//   done                 one-cycle completion pulse
//   mem                  scratchpad port (master side)
// Macro MMUL_SAT_EN (in mmul_mac): saturating accumulate.
module mmul_seq
  import mmul_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] c_base,
  output logic          busy,
  output logic          done,
  mmul_seq_if.master    mem
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mmul_state_e   state, state_next;
  logic [CW-1:0] i_q, j_q, k_q;
  logic [DW-1:0] acc, opa, opb, mac_out;
  logic [AW-1:0] a_base_q, b_base_q, c_base_q;

  logic last_i, last_j, last_k;
  assign last_i = (i_q == LAST);
  assign last_j = (j_q == LAST);
  assign last_k = (k_q == LAST);

  // byte offset of element (row, col); the base add wraps silently at 2^AW
  function automatic logic [AW-1:0] elem_off(input logic [CW-1:0] row,
                                             input logic [CW-1:0] col);
    return {{(AW-IW-2){1'b0}}, flat_idx(row, col, N), 2'b00};
  endfunction

  mmul_mac #(.DW(DW)) u_mac (
    .opa     (opa),
    .opb     (opb),
    .acc_in  (acc),
    .acc_out (mac_out)
  );

  always_comb begin
    state_next    = state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    done          = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_RD_A;
      S_RD_A: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = a_base_q + elem_off(i_q, k_q);
        if (mem.mem_gnt) state_next = S_WT_A;
      end
      S_WT_A: if (mem.mem_rvalid) state_next = S_RD_B;
      S_RD_B: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = b_base_q + elem_off(k_q, j_q);
        if (mem.mem_gnt) state_next = S_WT_B;
      end
      S_WT_B: if (mem.mem_rvalid) state_next = S_MAC;
      S_MAC:  state_next = last_k ? S_WR : S_RD_A;
      S_WR: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = c_base_q + elem_off(i_q, j_q);
        mem.mem_wdata = acc;
        if (mem.mem_gnt) state_next = (last_i && last_j) ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      case (state)
        S_IDLE: if (start) begin
          a_base_q <= a_base;
          b_base_q <= b_base;
          c_base_q <= c_base;
          i_q      <= '0;
          j_q      <= '0;
          k_q      <= '0;
          acc      <= '0;
        end
        S_WT_A: if (mem.mem_rvalid) opa <= mem.mem_rdata;
        S_WT_B: if (mem.mem_rvalid) opb <= mem.mem_rdata;
        S_MAC: begin
          acc <= mac_out;
          if (!last_k) k_q <= k_q + CW'(1);
        end
        S_WR: if (mem.mem_gnt) begin
          acc <= '0;
          k_q <= '0;
          if (last_j) begin
            j_q <= '0;
            i_q <= last_i ? '0 : i_q + CW'(1);
          end else begin
            j_q <= j_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmul_seq.sv
// tb/tb_mmul_seq.sv - self-checking bench for mmul_seq (N=2) with scratchpad model
module tb_mmul_seq;
  import mmul_seq_pkg::*;

  logic        clk, rstn, start;
  logic [31:0] a_base, b_base, c_base;
  logic        busy, done;
  logic [2:0]  alu_op;

  mmul_seq_if #(.AW(32), .DW(32)) mif ();

  mmul_seq #(.N(2), .DW(32), .AW(32)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .a_base (a_base),
    .b_base (b_base),
    .c_base (c_base),
    .busy   (busy),
    .done   (done),
    .mem    (mif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

`ifdef MMUL_SAT_EN
  localparam logic [31:0] SAT_C00 = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] SAT_C00 = 32'hFFFF_FFFE;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // scratchpad model and run bookkeeping
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] wlog_a[$], wlog_d[$], rlog[$];
  int          done_q[$];
  int          e0, busy_err, stall_cnt, hold_left, hold_err, late_cyc;
  bit          hold_on, rnd_mode, active, busy_chk;
  logic [31:0] hold_addr;
  bit          rd_pend;
  logic [31:0] rd_addr;
  int          rd_wait;

  logic [3:0][31:0] ma, mb, texp;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

`ifdef MMUL_SAT_EN
  function automatic longint sat32(input longint v);
    if (v > 64'sh7FFF_FFFF) return 64'sh7FFF_FFFF;
    if (v < -64'sh8000_0000) return -64'sh8000_0000;
    return v;
  endfunction
`endif

  // reference: C[i][j] = sum_k A[i][k]*B[k][j] in plain 64-bit arithmetic
  function automatic logic [31:0] model_elem(input int i, input int j);
    longint acc = 0;
    longint p;
    for (int k = 0; k < 2; k++) begin
      p = longint'($signed(ma[i*2+k])) * longint'($signed(mb[k*2+j]));
`ifdef MMUL_SAT_EN
      acc = sat32(acc + sat32(p));
`else
      acc = acc + p;
`endif
    end
    return acc[31:0];
  endfunction

  function automatic logic [3:0][31:0] pk(input logic [31:0] x0, x1, x2, x3);
    return {x3, x2, x1, x0};
  endfunction

  // memory responder and cycle monitor, acting just after each falling edge
  initial begin
    mif.mem_gnt = 1'b1; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    rd_pend = 0; active = 0; busy_chk = 0; rnd_mode = 0; hold_left = 0;
    forever begin
      bit g;
      int cyc;
      @(negedge clk);
      #1;
      cyc = ecount - e0;
      if (active) begin
        if (busy_chk && busy !== ((cyc >= 1) && (done_q.size() == 0))) busy_err++;
        if (done) done_q.push_back(cyc);
      end
      if (!rstn) begin
        rd_pend = 0; mif.mem_rvalid = 1'b0; mif.mem_gnt = 1'b1;
      end else begin
        if (rd_pend) begin
          if (rd_wait > 0) begin
            rd_wait--; mif.mem_rvalid = 1'b0;
            if (active) stall_cnt++;
          end else begin
            mif.mem_rvalid = 1'b1; mif.mem_rdata = mem_rd(rd_addr); rd_pend = 0;
          end
        end else if (rnd_mode && $urandom_range(3) == 0) begin
          mif.mem_rvalid = 1'b1; mif.mem_rdata = $urandom;
        end else begin
          mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'hDEAD_BEEF;
        end
        g = 1'b1;
        if (mif.mem_req) begin
          if (hold_left > 0 && (hold_on || (!mif.mem_we && mif.mem_addr == hold_addr))) begin
            hold_on = 1; g = 1'b0; hold_left--;
            if (mif.mem_we || mif.mem_addr != hold_addr) hold_err++;
          end else if (rnd_mode && $urandom_range(2) == 0) begin
            g = 1'b0;
          end
        end
        mif.mem_gnt = g;
        if (mif.mem_req && !g && active) stall_cnt++;
        if (mif.mem_req && g) begin
          if (mif.mem_we) begin
            mem_m[mif.mem_addr] = mif.mem_wdata;
            wlog_a.push_back(mif.mem_addr); wlog_d.push_back(mif.mem_wdata);
          end else begin
            rlog.push_back(mif.mem_addr);
            rd_pend = 1; rd_addr = mif.mem_addr;
            rd_wait = rnd_mode ? int'($urandom_range(2)) : late_cyc;
          end
        end
      end
    end
  end

  task automatic prep_run(input logic [31:0] ab, bb, input int stall_b, late, input bit rnd);
    for (int x = 0; x < 4; x++) begin
      mem_m[ab + 32'(4*x)] = ma[x];
      mem_m[bb + 32'(4*x)] = mb[x];
    end
    wlog_a.delete(); wlog_d.delete(); rlog.delete(); done_q.delete();
    busy_err = 0; stall_cnt = 0; hold_left = stall_b; hold_on = 0; hold_addr = bb;
    hold_err = 0; late_cyc = late; rnd_mode = rnd;
  endtask

  task automatic issue_start(input logic [31:0] ab, bb, cb);
    @(negedge clk);
    a_base = ab; b_base = bb; c_base = cb;
    alu_op = MATRIX_MUL;
    start = (alu_op == MATRIX_MUL);
    e0 = ecount; active = 1;
  endtask

  // exp_done < 0: expect 45 plus every stall cycle the responder introduced
  task automatic run_mmul(input string nm, input logic [31:0] ab, bb, cb,
                          input int stall_b, late, input bit rnd,
                          input int restart_at, input int exp_done);
    int lc = 0;
    int after = 0;
    prep_run(ab, bb, stall_b, late, rnd);
    busy_chk = 1;
    issue_start(ab, bb, cb);
    while (lc < 2000 && after < 12) begin
      @(negedge clk);
      lc++;
      start = (lc == restart_at);
      if (done_q.size() > 0) after++;
    end
    start = 1'b0; alu_op = 3'b000; active = 0; busy_chk = 0;
    chk({nm, " done_count"}, done_q.size(), 1);
    chk({nm, " done_cycle"}, (done_q.size() > 0) ? done_q[0] : -1,
        (exp_done < 0) ? 45 + stall_cnt : exp_done);
    chk({nm, " busy_profile_errs"}, busy_err, 0);
    chk({nm, " held_req_errs"}, hold_err, 0);
    chk({nm, " write_count"}, wlog_a.size(), 4);
    if (wlog_a.size() == 4) begin
      for (int e = 0; e < 4; e++) begin
        chk($sformatf("%s waddr[%0d]", nm, e), wlog_a[e], cb + 32'(4*e));
        chk($sformatf("%s wdata[%0d]", nm, e), wlog_d[e], texp[e]);
      end
    end
  endtask

  typedef struct {
    logic [3:0][31:0] a, b, c;
    int stall_b;
    int late;
    int restart_at;
    int done_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rstn = 1'b0; start = 1'b0; alu_op = 3'b000;
    a_base = 32'h0; b_base = 32'h0; c_base = 32'h0; e0 = 0;

    vecs[0] = '{pk(1,0,0,1), pk(1,2,3,4), pk(1,2,3,4), 0, 0, 0, 45};
    vecs[1] = '{pk(1,0,0,1), pk(1,2,3,4), pk(1,2,3,4), 3, 0, 0, 48};
    vecs[2] = '{pk(1,0,0,1), pk(1,2,3,4), pk(1,2,3,4), 0, 0, 10, 45};
    vecs[3] = '{pk(32'h7FFF_FFFF,0,0,0), pk(2,0,0,0), pk(SAT_C00,0,0,0), 0, 0, 0, 45};
    vecs[4] = '{pk(1,2,3,4), pk(5,6,7,8), pk(19,22,43,50), 0, 1, 0, 61};
    vecs[5] = '{pk(-1,2,3,-4), pk(5,-6,7,8), pk(9,22,-13,-50), 0, 0, 0, 45};

    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset mem_req", mif.mem_req, 0);
    chk("reset mem_we", mif.mem_we, 0);
    chk("reset mem_addr", mif.mem_addr, 0);
    chk("reset mem_wdata", mif.mem_wdata, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      ma = vecs[v].a; mb = vecs[v].b; texp = vecs[v].c;
      run_mmul($sformatf("vec%0d", v), 32'h0000_1000, 32'h0000_1040, 32'h0000_1080,
               vecs[v].stall_b, vecs[v].late, 1'b0, vecs[v].restart_at, vecs[v].done_cyc);
    end

    // address wraparound on A
    ma = pk(1,2,3,4); mb = pk(5,6,7,8); texp = pk(19,22,43,50);
    run_mmul("wrap", 32'hFFFF_FFF8, 32'h0000_0100, 32'h0000_0200, 0, 0, 1'b0, 0, 45);
    chk("wrap read_count", rlog.size(), 16);
    if (rlog.size() == 16) begin
      chk("wrap first_addr", rlog[0], 32'hFFFF_FFF8);
      chk("wrap wrapped_addr", rlog[8], 32'h0000_0000);
    end

    // reset in the middle of a run
    begin
      int lc = 0;
      ma = pk(1,0,0,1); mb = pk(1,2,3,4);
      prep_run(32'h2000, 32'h2040, 0, 0, 1'b0);
      busy_chk = 0;
      issue_start(32'h2000, 32'h2040, 32'h2080);
      while (lc < 20) begin
        @(negedge clk); lc++; start = 1'b0;
      end
      rstn = 1'b0;
      @(negedge clk);
      chk("midreset busy", busy, 0);
      chk("midreset mem_req", mif.mem_req, 0);
      rstn = 1'b1;
      repeat (30) @(negedge clk);
      active = 0; alu_op = 3'b000;
      chk("midreset no_done", done_q.size(), 0);
      chk("midreset partial_writes", wlog_a.size(), 1);
      texp = pk(1,2,3,4);
      run_mmul("after_reset", 32'h2000, 32'h2040, 32'h2080, 0, 0, 1'b0, 0, 45);
    end

    // randomized matrices and handshake timing against the reference model
    for (int r = 0; r < 8; r++) begin
      for (int x = 0; x < 4; x++) begin
        if (r % 2 == 0) begin
          ma[x] = 32'(int'($urandom_range(40)) - 20);
          mb[x] = 32'(int'($urandom_range(40)) - 20);
        end else begin
          ma[x] = $urandom; mb[x] = $urandom;
        end
      end
      for (int e = 0; e < 4; e++) texp[e] = model_elem(e / 2, e % 2);
      run_mmul($sformatf("rnd%0d", r), 32'h4000 + 32'(r*256), 32'h4040 + 32'(r*256),
               32'h4080 + 32'(r*256), 0, 0, 1'b1, 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
